axi4lite_modport_slave: RTL and testbench

//  AXI4-Lite slave register file: bus side of the team's AXI4-Lite interface slave modport.

---
 rtl/axi4lite_modport_slave_if.sv | 38 +++
 rtl/axi4lite_modport_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi4lite_modport_slave.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_modport_slave_if.sv
// AXI4-Lite bus bundle shared by the config-register manager and its slaves.
// The master modport drives requests; the slave modport drives responses.
interface axi4lite_modport_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_modport_slave.sv
// AXI4-Lite register file: NUM_REGS byte-strobed registers behind the slave modport,
// with decode errors and all registers exported in parallel on regs_o.
module axi4lite_modport_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi4lite_modport_slave_if.slave        bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int HI     = LSB + IDX_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'b00, RD_WAIT = 2'b01, RD_RESP = 2'b10} rd_state_t;

  // Any address bit above the register window set means the access is out of range.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[ADDR_WIDTH-1:HI];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_strobe(
    input logic [DATA_WIDTH-1:0] old_d,
    input logic [DATA_WIDTH-1:0] new_d,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    for (int i = 0; i < STRB_W; i++) begin
      res[i*8 +: 8] = strb[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  wr_state_t             wr_state_r, wr_state_nxt_s;
  logic                  awready_r, awready_nxt_s;
  logic                  wready_r, wready_nxt_s;
  logic                  aw_full_r, aw_full_nxt_s;
  logic                  w_full_r, w_full_nxt_s;
  logic                  bvalid_r, bvalid_nxt_s;
  logic [1:0]            bresp_r, bresp_nxt_s;
  logic                  commit_s;
  logic                  aw_hs_s, w_hs_s;
  logic [IDX_W-1:0]      aw_idx_r;
  logic                  aw_err_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]     wstrb_r;

  rd_state_t             rd_state_r, rd_state_nxt_s;
  logic                  arready_r, arready_nxt_s;
  logic                  rvalid_r, rvalid_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_nxt_s;
  logic [1:0]            rresp_r, rresp_nxt_s;
  logic [DATA_WIDTH-1:0] rcap_data_r, rcap_data_nxt_s;
  logic                  rcap_err_r, rcap_err_nxt_s;
  logic                  ar_hs_s;
  logic                  unused_s;

  assign aw_hs_s  = bus.awvalid && awready_r;
  assign w_hs_s   = bus.wvalid && wready_r;
  assign ar_hs_s  = bus.arvalid && arready_r;
  assign unused_s = ^{bus.awprot, bus.arprot, bus.awaddr[LSB-1:0], bus.araddr[LSB-1:0]};

  // Write FSM: collect AW and W independently, commit one edge after both are held.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    awready_nxt_s  = awready_r;
    wready_nxt_s   = wready_r;
    aw_full_nxt_s  = aw_full_r;
    w_full_nxt_s   = w_full_r;
    bvalid_nxt_s   = bvalid_r;
    bresp_nxt_s    = bresp_r;
    commit_s       = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        if (aw_full_r && w_full_r) begin
          commit_s       = !aw_err_r;
          bvalid_nxt_s   = 1'b1;
          bresp_nxt_s    = aw_err_r ? RESP_SLVERR : RESP_OKAY;
          awready_nxt_s  = 1'b0;
          wready_nxt_s   = 1'b0;
          wr_state_nxt_s = WR_RESP;
        end else begin
          aw_full_nxt_s = aw_full_r || aw_hs_s;
          w_full_nxt_s  = w_full_r || w_hs_s;
          awready_nxt_s = !(aw_full_r || aw_hs_s);
          wready_nxt_s  = !(w_full_r || w_hs_s);
        end
      end
      WR_RESP: begin
        if (bus.bready) begin
          bvalid_nxt_s   = 1'b0;
          awready_nxt_s  = 1'b1;
          wready_nxt_s   = 1'b1;
          aw_full_nxt_s  = 1'b0;
          w_full_nxt_s   = 1'b0;
          wr_state_nxt_s = WR_IDLE;
        end else begin
          bvalid_nxt_s   = 1'b1;
        end
      end
      default: begin
        wr_state_nxt_s = WR_IDLE;
        awready_nxt_s  = 1'b0;
        wready_nxt_s   = 1'b0;
        aw_full_nxt_s  = 1'b0;
        w_full_nxt_s   = 1'b0;
        bvalid_nxt_s   = 1'b0;
      end
    endcase
  end

  // Write FSM state and response registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_r <= WR_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      aw_full_r  <= 1'b0;
      w_full_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      awready_r  <= awready_nxt_s;
      wready_r   <= wready_nxt_s;
      aw_full_r  <= aw_full_nxt_s;
      w_full_r   <= w_full_nxt_s;
      bvalid_r   <= bvalid_nxt_s;
      bresp_r    <= bresp_nxt_s;
    end
  end

  // Capture decoded write address and write data at their handshakes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_r <= {IDX_W{1'b0}};
      aw_err_r <= 1'b0;
      wdata_r  <= {DATA_WIDTH{1'b0}};
      wstrb_r  <= {STRB_W{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_idx_r <= bus.awaddr[LSB +: IDX_W];
        aw_err_r <= addr_err(bus.awaddr);
      end
      if (w_hs_s) begin
        wdata_r <= bus.wdata;
        wstrb_r <= bus.wstrb;
      end
    end
  end

  // Register file storage with byte-strobed commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      regs_r[aw_idx_r] <= apply_strobe(regs_r[aw_idx_r], wdata_r, wstrb_r);
    end
  end

  // Read FSM: data is sampled at the AR handshake, so a same-edge write is not yet visible.
  always_comb begin
    rd_state_nxt_s  = rd_state_r;
    arready_nxt_s   = arready_r;
    rvalid_nxt_s    = rvalid_r;
    rdata_nxt_s     = rdata_r;
    rresp_nxt_s     = rresp_r;
    rcap_data_nxt_s = rcap_data_r;
    rcap_err_nxt_s  = rcap_err_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) begin
          arready_nxt_s   = 1'b0;
          rcap_err_nxt_s  = addr_err(bus.araddr);
          rcap_data_nxt_s = addr_err(bus.araddr) ? {DATA_WIDTH{1'b0}}
                                                 : regs_r[bus.araddr[LSB +: IDX_W]];
          rd_state_nxt_s  = RD_WAIT;
        end else begin
          arready_nxt_s   = 1'b1;
        end
      end
      RD_WAIT: begin
        rvalid_nxt_s   = 1'b1;
        rdata_nxt_s    = rcap_data_r;
        rresp_nxt_s    = rcap_err_r ? RESP_SLVERR : RESP_OKAY;
        rd_state_nxt_s = RD_RESP;
      end
      RD_RESP: begin
        if (bus.rready) begin
          rvalid_nxt_s   = 1'b0;
          arready_nxt_s  = 1'b1;
          rd_state_nxt_s = RD_IDLE;
        end else begin
          rvalid_nxt_s   = 1'b1;
        end
      end
      default: begin
        rd_state_nxt_s = RD_IDLE;
        arready_nxt_s  = 1'b0;
        rvalid_nxt_s   = 1'b0;
      end
    endcase
  end

  // Read FSM state and response registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_r  <= RD_IDLE;
      arready_r   <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      rresp_r     <= 2'b00;
      rcap_data_r <= {DATA_WIDTH{1'b0}};
      rcap_err_r  <= 1'b0;
    end else begin
      rd_state_r  <= rd_state_nxt_s;
      arready_r   <= arready_nxt_s;
      rvalid_r    <= rvalid_nxt_s;
      rdata_r     <= rdata_nxt_s;
      rresp_r     <= rresp_nxt_s;
      rcap_data_r <= rcap_data_nxt_s;
      rcap_err_r  <= rcap_err_nxt_s;
    end
  end

  // Flatten the register array onto the fabric-side bus.
  always_comb begin
    regs_o = {(NUM_REGS*DATA_WIDTH){1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[k];
    end
  end

  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = bresp_r;
  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
endmodule

// File: tb/tb_axi4lite_modport_slave.sv
// Directed bench for axi4lite_modport_slave: tasks push expected B/R responses into
// queues and a negedge monitor pops and compares them at each handshake.
module tb_axi4lite_modport_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } r_exp_t;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic [NR*DW-1:0] regs_o;

  axi4lite_modport_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4lite_modport_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus),
    .regs_o  (regs_o)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_b_q [$];
  r_exp_t      exp_r_q [$];
  logic [DW-1:0] exp_regs [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_regs(input string name);
    for (int k = 0; k < NR; k++) chk(name, regs_o[k*DW +: DW], exp_regs[k]);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold-stability under stalls.
  initial begin
    logic          b_stall = 1'b0;
    logic          r_stall = 1'b0;
    logic [1:0]    b_held = 2'b00;
    r_exp_t        r_held;
    r_exp_t        re;
    logic [1:0]    be;
    r_held = '{data: 32'h0, resp: 2'b00};
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        b_stall = 1'b0;
        r_stall = 1'b0;
      end else begin
        if (b_stall) chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, b_held});
        if (r_stall) chk("r_hold", {bus.rvalid, bus.rdata, bus.rresp}, {1'b1, r_held.data, r_held.resp});
        if (bus.bvalid && bus.bready) begin
          if (exp_b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected actual=bresp %h required=no response", bus.bresp);
          end else begin
            be = exp_b_q.pop_front();
            chk("bresp", bus.bresp, be);
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected actual=rdata %h required=no response", bus.rdata);
          end else begin
            re = exp_r_q.pop_front();
            chk("rdata", bus.rdata, re.data);
            chk("rresp", bus.rresp, re.resp);
          end
        end
        b_stall = bus.bvalid && !bus.bready;
        b_held  = bus.bresp;
        r_stall = bus.rvalid && !bus.rready;
        r_held  = '{data: bus.rdata, resp: bus.rresp};
      end
    end
  end

  task automatic write_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int w_lead, input int bhold,
                           input logic [1:0] exp);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    int cyc = 0;
    int idx;
    exp_b_q.push_back(exp);
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc >= w_lead && !aw_done) bus.awvalid = 1'b1;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      cyc++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    chk("b_early", bus.bvalid, 1'b0);
    tick();
    chk("b_latency", bus.bvalid, 1'b1);
    for (int i = 0; i < bhold; i++) begin
      chk("wr_ready_low", {bus.awready, bus.wready}, 2'b00);
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("b_release", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
    if (exp == 2'b00) begin
      idx = int'(addr[5:2]);
      for (int b = 0; b < 4; b++) if (strb[b]) exp_regs[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic read_txn(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                          input logic [1:0] exp_resp, input int rhold);
    bit hs = 1'b0;
    int cyc = 0;
    exp_r_q.push_back('{data: exp_data, resp: exp_resp});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!hs && cyc < 40) begin
      hs = bus.arvalid && bus.arready;
      tick();
      cyc++;
    end
    bus.arvalid = 1'b0;
    chk("rd_accept", hs, 1'b1);
    chk("r_early", {bus.rvalid, bus.arready}, 2'b00);
    tick();
    chk("r_latency", bus.rvalid, 1'b1);
    repeat (rhold) tick();
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("r_release", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  initial begin
    ARESETN     = 1'b0;
    bus.awaddr  = 32'h0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata   = 32'h0; bus.wstrb  = 4'h0;   bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = 32'h0; bus.arprot = 3'b000; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    for (int k = 0; k < NR; k++) exp_regs[k] = 32'h0;

    // Reset state and first edge after release.
    repeat (3) tick();
    chk("rst_outputs", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready,
                        bus.rvalid, bus.rresp, bus.rdata}, 41'h0);
    check_regs("rst_regs");
    ARESETN = 1'b1;
    chk("rst_ready_pre", {bus.awready, bus.wready, bus.arready}, 3'b000);
    tick();
    chk("rst_ready_post", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Full-word write with AW and W together, then read back.
    write_txn(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    read_txn(32'h04, 32'hDEADBEEF, 2'b00, 0);

    // Partial strobe: 0x11223344 merged with 0xAABBCCDD on bytes 0 and 2.
    write_txn(32'h08, 32'h11223344, 4'hF, 0, 0, 2'b00);
    write_txn(32'h08, 32'hAABBCCDD, 4'h5, 0, 0, 2'b00);
    read_txn(32'h08, 32'h11BB33DD, 2'b00, 0);

    // W two cycles ahead of AW, BREADY held off for three cycles.
    write_txn(32'h0C, 32'hCAFEF00D, 4'hF, 2, 3, 2'b00);
    read_txn(32'h0C, 32'hCAFEF00D, 2'b00, 0);
    check_regs("regs_after_writes");

    // Last register via an unaligned address; low address bits are ignored.
    write_txn(32'h3F, 32'h0BADF00D, 4'hF, 0, 0, 2'b00);
    read_txn(32'h3D, 32'h0BADF00D, 2'b00, 0);

    // First out-of-range address: SLVERR, zero data, no register change.
    write_txn(32'h40, 32'h12345678, 4'hF, 0, 0, 2'b10);
    read_txn(32'h40, 32'h00000000, 2'b10, 0);
    check_regs("regs_after_decerr");

    // Stalled read response while an unrelated write completes.
    fork
      read_txn(32'h04, 32'hDEADBEEF, 2'b00, 4);
      write_txn(32'h10, 32'h55AA55AA, 4'hF, 0, 0, 2'b00);
    join
    read_txn(32'h10, 32'h55AA55AA, 2'b00, 0);
    check_regs("regs_after_overlap");

    // Reset with AW captured and W still pending.
    bus.awaddr  = 32'h14;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t6_aw_captured", {bus.awready, bus.wready}, 2'b01);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("t6_async_outputs", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready,
                             bus.rvalid, bus.rresp, bus.rdata}, 41'h0);
    for (int k = 0; k < NR; k++) exp_regs[k] = 32'h0;
    check_regs("t6_regs_in_reset");
    bus.wdata  = 32'hFFFFFFFF;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    repeat (2) tick();
    ARESETN    = 1'b1;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    repeat (6) tick();
    chk("t6_no_bvalid", bus.bvalid, 1'b0);
    check_regs("t6_regs_after");
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    tick();

    chk("b_queue_drained", exp_b_q.size(), 0);
    chk("r_queue_drained", exp_r_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
